// File: rtl/rng_pkg.sv
// rng_pkg: types shared between the range generator and its inverse extractor.
//   cfg_t   - packed range configuration {incr, cnt, base} at default widths
//   ext_t   - extractor result {err, cfg}
//   state_t - extractor FSM states
package rng_pkg;
    localparam int DEF_W_INCR  = 16;
    localparam int DEF_W_CNT   = 16;
    localparam int DEF_W_START = 16;

    typedef struct packed {
        logic [DEF_W_INCR-1:0]  incr;
        logic [DEF_W_CNT-1:0]   cnt;
        logic [DEF_W_START-1:0] base;
    } cfg_t;

    typedef struct packed {
        logic err;
        cfg_t cfg;
    } ext_t;

    typedef enum logic [1:0] {FIRST, ACC, OUT} state_t;
endpackage

// File: rtl/rng_extract_if.sv
// rng_extract_if: valid/ready stream bundle.
//   data  - payload, W bits
//   valid - producer has data
//   ready - consumer can take data
//   master drives data/valid, slave drives ready.
interface rng_extract_if #(parameter int W = 17) ();
    logic [W-1:0] data;
    logic         valid;
    logic         ready;
    modport master(output data, output valid, input ready);
    modport slave(input data, input valid, output ready);
endinterface

// File: rtl/rng_extract.sv
// rng_extract: recovers {err, incr, cnt, base} from an eot-terminated stream.
//   clk  - clock
//   rst  - synchronous active-high reset, aborts any partial stream
//   din  - slave stream, data = {eot, value[W_DATA-1:0]}
//   dout - master stream, data = {err, incr, cnt, base}
module rng_extract
    import rng_pkg::*;
#(
    parameter int W_DATA  = 16,
    parameter int W_INCR  = 16,
    parameter int W_CNT   = 16,
    parameter int W_START = 16,
    parameter bit SIGNED  = 1'b0
) (
    input logic           clk,
    input logic           rst,
    rng_extract_if.slave  din,
    rng_extract_if.master dout
);
    localparam int WX = W_DATA + 1;

    if ($bits(din.data) != W_DATA + 1 || $bits(dout.data) != 1 + W_INCR + W_CNT + W_START) begin : g_width_chk
        $fatal(1, "rng_extract: interface widths do not match parameters");
    end

    state_t               state_q, state_d;
    logic [W_START-1:0]   base_q, base_d;
    logic [W_INCR-1:0]    incr_q, incr_d;
    logic [W_CNT-1:0]     cnt_q, cnt_d;
    logic [W_DATA-1:0]    prev_q, prev_d;
    logic                 err_q, err_d;
    logic                 have_q, have_d;

    logic [W_DATA-1:0]    val;
    logic                 eot, xfer;
    logic [WX-1:0]        val_x, prev_x, diff;
    logic [W_START-1:0]   base_new;
    logic [W_INCR-1:0]    incr_new;

    assign val       = din.data[W_DATA-1:0];
    assign eot       = din.data[W_DATA];
    assign din.ready = state_q != OUT;
    assign xfer      = din.valid & din.ready;
    assign dout.valid = state_q == OUT;
    assign dout.data  = {err_q, incr_q, cnt_q, base_q};

    // One extra bit keeps the difference exact before it is folded to W_INCR.
    assign val_x    = SIGNED ? {val[W_DATA-1], val} : {1'b0, val};
    assign prev_x   = SIGNED ? {prev_q[W_DATA-1], prev_q} : {1'b0, prev_q};
    assign diff     = val_x - prev_x;
    assign incr_new = W_INCR'(signed'(diff));
    assign base_new = SIGNED ? W_START'(signed'(val)) : W_START'(val);

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        incr_d  = incr_q;
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        err_d   = err_q;
        have_d  = have_q;
        if (state_q == FIRST && xfer) begin
            base_d  = base_new;
            prev_d  = val;
            cnt_d   = W_CNT'(1);
            incr_d  = '0;
            err_d   = 1'b0;
            have_d  = 1'b0;
            state_d = eot ? OUT : ACC;
        end else if (state_q == ACC && xfer) begin
            if (!have_q) begin
                incr_d = incr_new;
                have_d = 1'b1;
            end else if (incr_new != incr_q) begin
                err_d = 1'b1;
            end
            // A saturated count can no longer describe the stream.
            if (&cnt_q) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + W_CNT'(1);
            end
            prev_d  = val;
            state_d = eot ? OUT : ACC;
        end else if (state_q == OUT && dout.ready) begin
            state_d = FIRST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FIRST;
            base_q  <= '0;
            incr_q  <= '0;
            cnt_q   <= '0;
            prev_q  <= '0;
            err_q   <= 1'b0;
            have_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            incr_q  <= incr_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            err_q   <= err_d;
            have_q  <= have_d;
        end
    end
endmodule

// File: tb/tb_rng_extract.sv
// tb_rng_extract: self-checking bench for rng_extract (unsigned, signed and 2-bit count variants).
module tb_rng_extract;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv [3];
    logic [16:0] id [3];
    logic        ordy [3];
    logic        ir [3];
    logic        ov [3];
    logic [48:0] od [3];

    int checks = 0;
    int errors = 0;
    logic [15:0] s[$];

    rng_extract_if #(17) din0 ();
    rng_extract_if #(17) din1 ();
    rng_extract_if #(17) din2 ();
    rng_extract_if #(49) dout0 ();
    rng_extract_if #(49) dout1 ();
    rng_extract_if #(35) dout2 ();

    rng_extract #(.SIGNED(1'b0)) u0 (.clk(clk), .rst(rst), .din(din0.slave), .dout(dout0.master));
    rng_extract #(.SIGNED(1'b1)) u1 (.clk(clk), .rst(rst), .din(din1.slave), .dout(dout1.master));
    rng_extract #(.W_CNT(2))     u2 (.clk(clk), .rst(rst), .din(din2.slave), .dout(dout2.master));

    assign din0.valid = iv[0];
    assign din1.valid = iv[1];
    assign din2.valid = iv[2];
    assign din0.data  = id[0];
    assign din1.data  = id[1];
    assign din2.data  = id[2];
    assign dout0.ready = ordy[0];
    assign dout1.ready = ordy[1];
    assign dout2.ready = ordy[2];
    assign ir[0] = din0.ready;
    assign ir[1] = din1.ready;
    assign ir[2] = din2.ready;
    assign ov[0] = dout0.valid;
    assign ov[1] = dout1.valid;
    assign ov[2] = dout2.valid;
    assign od[0] = dout0.data;
    assign od[1] = dout1.data;
    assign od[2] = {14'b0, dout2.data};

    task automatic chk(input string tag, input logic [48:0] obs, input logic [48:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: base is the first value, incr the first step, every later
    // step must equal it, and the count clips at the field maximum.
    function automatic logic [48:0] model(input int k);
        int n = s.size();
        int maxc = (k == 2) ? 3 : 65535;
        logic [15:0] inc;
        logic [15:0] c;
        logic e;
        inc = (n > 1) ? 16'(s[1] - s[0]) : 16'h0;
        e = 1'b0;
        for (int i = 2; i < n; i++)
            if (16'(s[i] - s[i-1]) != inc) e = 1'b1;
        if (n > maxc) e = 1'b1;
        c = 16'((n > maxc) ? maxc : n);
        return (k == 2) ? {14'b0, e, inc, c[1:0], s[0]} : {e, inc, c, s[0]};
    endfunction

    task automatic send(input int k, input bit gaps, input int n);
        int wt;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    iv[k] = 1'b0;
                    @(posedge clk); #1;
                end
            end
            iv[k] = 1'b1;
            id[k] = {i == s.size() - 1, s[i]};
            wt = 0;
            while (!ir[k] && wt < 50) begin
                @(posedge clk); #1;
                wt++;
            end
            if (!ir[k]) chk("din_ready_timeout", 49'(ir[k]), 49'd1);
            @(posedge clk); #1;
        end
        iv[k] = 1'b0;
    endtask

    task automatic stream(input int k, input bit gaps, input int hold, output logic [48:0] res);
        logic [48:0] exp;
        exp = model(k);
        ordy[k] = (hold == 0);
        send(k, gaps, s.size());
        chk("latency_valid", 49'(ov[k]), 49'd1);
        chk("result", od[k], exp);
        res = od[k];
        if (hold > 0) begin
            iv[k] = 1'b1;
            id[k] = 17'h00000;
            repeat (hold) begin
                @(posedge clk); #1;
                chk("hold_valid", 49'(ov[k]), 49'd1);
                chk("hold_din_ready", 49'(ir[k]), 49'd0);
                chk("hold_data", od[k], exp);
            end
            iv[k] = 1'b0;
            ordy[k] = 1'b1;
        end
        @(posedge clk); #1;
        chk("drain_valid", 49'(ov[k]), 49'd0);
        chk("bubble_ready", 49'(ir[k]), 49'd1);
    endtask

    initial begin
        logic [48:0] r1, r2;
        int len;
        logic [15:0] b, inc;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0;
            id[k] = '0;
            ordy[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_valid", 49'(ov[k]), 49'd0);
            chk("reset_ready", 49'(ir[k]), 49'd1);
            chk("reset_data", od[k], 49'd0);
        end
        rst = 1'b0;

        s = '{16'd5, 16'd8, 16'd11, 16'd14};
        stream(0, 1'b0, 0, r1);
        chk("arith", r1, {1'b0, 16'd3, 16'd4, 16'd5});

        s = '{16'd7};
        stream(0, 1'b0, 0, r1);
        chk("single", r1, {1'b0, 16'd0, 16'd1, 16'd7});

        s = '{16'd2, 16'd4, 16'd7};
        stream(0, 1'b0, 0, r1);
        chk("broken", r1, {1'b1, 16'd2, 16'd3, 16'd2});
        s = '{16'd1, 16'd2};
        stream(0, 1'b0, 0, r1);
        chk("err_cleared", r1, {1'b0, 16'd1, 16'd2, 16'd1});

        s = '{16'd10, 16'd7, 16'd4};
        stream(1, 1'b0, 0, r1);
        chk("signed_desc", r1, {1'b0, 16'hFFFD, 16'd3, 16'd10});

        s = '{16'hFFFF, 16'h0002};
        stream(0, 1'b0, 0, r1);
        chk("unsigned_wrap", r1, {1'b0, 16'd3, 16'd2, 16'hFFFF});

        s = '{16'd100, 16'd90, 16'd80};
        stream(0, 1'b0, 5, r1);
        s = '{16'd1, 16'd3};
        stream(0, 1'b0, 0, r1);
        chk("after_backpressure", r1, {1'b0, 16'd2, 16'd2, 16'd1});

        s = '{16'd9, 16'd13, 16'd17, 16'd21, 16'd25};
        stream(0, 1'b1, 0, r1);
        stream(0, 1'b0, 0, r2);
        chk("gaps_match", r1, r2);

        s = '{16'd4, 16'd5, 16'd6, 16'd7};
        send(0, 1'b0, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_no_dout", 49'(ov[0]), 49'd0);
        end
        chk("abort_ready", 49'(ir[0]), 49'd1);
        s = '{16'd0, 16'd1, 16'd2};
        stream(0, 1'b0, 0, r1);
        chk("after_abort", r1, {1'b0, 16'd1, 16'd3, 16'd0});

        s = '{16'd3, 16'd6};
        ordy[1] = 1'b0;
        send(1, 1'b0, 2);
        chk("pending_valid", 49'(ov[1]), 49'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_out_valid", 49'(ov[1]), 49'd0);
        ordy[1] = 1'b1;

        s = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
        stream(2, 1'b0, 0, r1);
        chk("cnt_saturate", r1, {14'b0, 1'b1, 16'd1, 2'd3, 16'd1});

        for (int r = 0; r < 12; r++) begin
            len = $urandom_range(1, 6);
            b = 16'($urandom);
            inc = 16'($urandom);
            s = {};
            for (int i = 0; i < len; i++) s.push_back(16'(b + inc * 16'(i)));
            if (len > 2 && $urandom_range(0, 3) == 0) s[len-1] = s[len-1] + 16'd1;
            for (int k = 0; k < 3; k++) stream(k, r[0], 0, r1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
